mii_frame_monitor: RTL and testbench
====================================

// Module: mii_frame_monitor
// PURPOSE
//  Downstream consumer of the 4-bit MII transmit stream from the packet generator.
//  Strips the preamble and SFD, then assembles nibbles into bytes.
//  Checks CRC-32, length and nibble alignment, and extracts DA/SA/EtherType.
//  Reports per-frame status; the status feeds link self-test and register readback.
// PARAMETERS
//  MIN_LEN   64    minimum legal frame length in bytes (DA..FCS); shorter = runt
//  MAX_LEN   1522  maximum legal frame length in bytes; longer = giant
// PORTS
//  clock          in   1   single clock; one nibble sampled per cycle while io_mii_en=1
//  reset          in   1   synchronous, active-low
//  io_mii_en      in   1   frame enable (tx_en of upstream stage)
//  io_mii_dat     in   4   nibble data, low nibble of each byte first
//  io_stats_clr   in   1   clears frame counters (only with MII_FRAME_STATS_EN)
//  io_byte_valid  out  1   io_byte_data valid this cycle (DA..FCS bytes only)
//  io_byte_data   out  8   assembled byte
//  io_frame_done  out  1   1-cycle pulse at end of every frame that reached DATA state
//  io_frame_ok    out  1   status of last frame; valid with io_frame_done and held until next done
//  io_frame_len   out  16  byte count of last frame (DA..FCS), saturates at 0xFFFF
//  io_da          out  48  DA of last frame, first byte on wire in [47:40]
//  io_sa          out  48  SA of last frame, same byte order
//  io_etype       out  16  EtherType/length of last frame, first byte in [15:8]
//  io_good_cnt    out  32  frames with io_frame_ok=1 (macro only)
//  io_bad_cnt     out  32  frames with io_frame_ok=0 (macro only)
// BEHAVIOUR
//  Reset (reset=0 at a clock edge): every output = 0; FSM = IDLE.
//   Reset mid-frame discards the frame; no io_frame_done is produced.
//  FSM states: IDLE, PREAMBLE, DATA, DROP.
//   IDLE: en=1 with nibble 0x5 -> PREAMBLE; en=1 with any other nibble -> DROP.
//   PREAMBLE: 0x5 -> stay; 0xD -> DATA (SFD = byte 0xD5); other nibble -> DROP;
//    en=0 -> IDLE with no done pulse.
//   DATA: even nibble count = low nibble, odd count = high nibble; byte completes on the high nibble.
//    en=0 -> IDLE; io_frame_done pulses the cycle after the first en=0 sample.
//   DROP: wait for en=0 -> IDLE; no done pulse; counters unchanged.
//  Byte path: io_byte_valid/io_byte_data registered one cycle after the high nibble is sampled.
//   A trailing odd nibble (dribble) is not emitted as a byte.
//  CRC: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) over every byte including the FCS.
//   CRC is correct when the register equals residue 0xC704DD7B.
//  io_frame_ok = residue match AND even nibble count AND MIN_LEN <= len <= MAX_LEN.
//  Length counter: 16-bit, saturating, never wraps.
//  Header capture: bytes 0..13 go into shadow registers.
//   io_da/io_sa/io_etype/io_frame_len/io_frame_ok update only on the done cycle.
//   Frames shorter than 14 bytes: the unreceived header bytes load 0.
//  Back-to-back frames: en may rise the cycle after it falls.
//   IDLE accepts the new frame in the same cycle that the done pulse of the previous frame is issued.
// CONFIGURATION
//  MII_FRAME_STATS_EN defined: io_good_cnt/io_bad_cnt present.
//   Counters are 32-bit, wrap 0xFFFFFFFF -> 0, and increment on io_frame_done.
//   io_stats_clr zeroes both counters.
//   io_stats_clr coincident with io_frame_done: cleared, then the increment applies (result = 1).
//  MII_FRAME_STATS_EN undefined: counter logic is removed; both outputs are tied to 0.
//   io_stats_clr is ignored.
// STRUCTURE
//  Package eth_mii_pkg holds:
//   - FSM state enum
//   - PREAMBLE_NIB=4'h5, SFD_NIB=4'hD, CRC32_RESIDUE=32'hC704DD7B, CRC32_INIT
//   - function crc32_d8(crc, byte) returning the next CRC
//  Sub-module crc32_d8_reg: registered byte-wise CRC with init/enable. It is shared with the future RX path.
// TESTING
//  1. Send 15x nibble 5, then D, then 60 bytes (DA=0x0A0B0C0D0E0F, SA=0x112233445566, etype=0x0800) and a valid FCS.
//     Expect: one done pulse, ok=1, len=64, fields match, good_cnt=1.
//  2. Same frame with a single payload nibble flipped -> ok=0, len=64, bad_cnt=1, good_cnt unchanged.
//  3. Valid 64-byte frame plus one extra nibble before en falls -> ok=0 (dribble), 64 byte_valid pulses.
//  4. 60-byte frame with a correct FCS -> ok=0 (runt), len=60. A 1523-byte frame -> ok=0, len=1523.
//  5. Preamble containing nibble 0x3 -> no byte_valid, no done pulse, counters unchanged.
//     A following good frame -> ok=1.
//  6. Assert reset mid-DATA -> all outputs 0, no done pulse.
//     Next frame good -> ok=1, good_cnt=1.
//     Then stats_clr on the done cycle -> good_cnt=1.

Source files
------------

// File: rtl/eth_mii_pkg.sv
// Shared MII/Ethernet definitions: FSM states, framing nibbles, CRC-32 constants
// and the byte-wise CRC-32 next-state function.
package eth_mii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } mii_state_e;

  localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
  localparam logic [3:0]  SFD_NIB       = 4'hD;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;

  // The register is kept MSB-first with the normal polynomial while data bits are
  // consumed LSB-first, which is the bit-mirror of the reflected form. In this
  // orientation a good frame (FCS included) leaves exactly CRC32_RESIDUE behind.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data_byte);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data_byte[i];
      c  = {c[30:0], 1'b0};
      if (fb) begin
        c = c ^ CRC32_POLY;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/mii_frame_monitor_if.sv
// Bus bundle between the MII transmit source (master) and the frame monitor (slave).
interface mii_frame_monitor_if;

  logic        io_mii_en;
  logic [3:0]  io_mii_dat;
  logic        io_stats_clr;
  logic        io_byte_valid;
  logic [7:0]  io_byte_data;
  logic        io_frame_done;
  logic        io_frame_ok;
  logic [15:0] io_frame_len;
  logic [47:0] io_da;
  logic [47:0] io_sa;
  logic [15:0] io_etype;
  logic [31:0] io_good_cnt;
  logic [31:0] io_bad_cnt;

  modport master (
    output io_mii_en, io_mii_dat, io_stats_clr,
    input  io_byte_valid, io_byte_data, io_frame_done, io_frame_ok, io_frame_len,
    input  io_da, io_sa, io_etype, io_good_cnt, io_bad_cnt
  );

  modport slave (
    input  io_mii_en, io_mii_dat, io_stats_clr,
    output io_byte_valid, io_byte_data, io_frame_done, io_frame_ok, io_frame_len,
    output io_da, io_sa, io_etype, io_good_cnt, io_bad_cnt
  );

endinterface

// File: rtl/crc32_d8_reg.sv
// Registered byte-wise CRC-32 with synchronous init and per-byte enable.
// Init has priority over enable; the register idles at CRC32_INIT after reset.
module crc32_d8_reg
  import eth_mii_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        init,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_d;
  logic [31:0] crc_q;

  // Next CRC: restart, fold in one byte, or hold
  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC32_INIT;
    end else if (enable) begin
      crc_d = crc32_d8(crc_q, data);
    end
  end

  // CRC register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/mii_frame_monitor.sv
// MII transmit-stream frame monitor: strips preamble/SFD, assembles bytes,
// checks CRC-32, length and nibble alignment, captures DA/SA/EtherType.
// Optional frame counters are built when MII_FRAME_STATS_EN is defined.
module mii_frame_monitor
  import eth_mii_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1522
) (
  input logic                clock,
  input logic                reset,
  mii_frame_monitor_if.slave bus
);

  localparam logic [15:0] MIN_LEN16 = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

  mii_state_e   state_d, state_q;
  logic [3:0]   lo_nib_d, lo_nib_q;
  logic         nib_odd_d, nib_odd_q;
  logic [15:0]  len_d, len_q;
  logic [111:0] hdr_d, hdr_q;
  logic         byte_valid_d, byte_valid_q;
  logic [7:0]   byte_data_d, byte_data_q;
  logic         done_d, done_q;
  logic         ok_d, ok_q;
  logic [15:0]  frame_len_d, frame_len_q;
  logic [47:0]  da_d, da_q;
  logic [47:0]  sa_d, sa_q;
  logic [15:0]  etype_d, etype_q;

  logic         crc_init;
  logic         crc_en;
  logic [7:0]   crc_byte;
  logic [31:0]  crc_val;

  crc32_d8_reg u_crc (
    .clock  (clock),
    .reset  (reset),
    .init   (crc_init),
    .enable (crc_en),
    .data   (crc_byte),
    .crc    (crc_val)
  );

  // Framing FSM next state plus byte assembly, header shadow and end-of-frame status
  always_comb begin
    state_d      = state_q;
    lo_nib_d     = lo_nib_q;
    nib_odd_d    = nib_odd_q;
    len_d        = len_q;
    hdr_d        = hdr_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    done_d       = 1'b0;
    ok_d         = ok_q;
    frame_len_d  = frame_len_q;
    da_d         = da_q;
    sa_d         = sa_q;
    etype_d      = etype_q;
    crc_init     = 1'b0;
    crc_en       = 1'b0;
    crc_byte     = {bus.io_mii_dat, lo_nib_q};

    case (state_q)
      ST_IDLE: begin
        if (bus.io_mii_en) begin
          state_d = (bus.io_mii_dat == PREAMBLE_NIB) ? ST_PREAMBLE : ST_DROP;
        end
      end

      ST_PREAMBLE: begin
        if (!bus.io_mii_en) begin
          state_d = ST_IDLE;
        end else if (bus.io_mii_dat == SFD_NIB) begin
          state_d   = ST_DATA;
          crc_init  = 1'b1;
          len_d     = '0;
          nib_odd_d = 1'b0;
          hdr_d     = '0;
        end else if (bus.io_mii_dat != PREAMBLE_NIB) begin
          state_d = ST_DROP;
        end
      end

      ST_DATA: begin
        if (bus.io_mii_en) begin
          if (!nib_odd_q) begin
            lo_nib_d  = bus.io_mii_dat;
            nib_odd_d = 1'b1;
          end else begin
            nib_odd_d    = 1'b0;
            byte_valid_d = 1'b1;
            byte_data_d  = crc_byte;
            crc_en       = 1'b1;
            for (int i = 0; i < 14; i++) begin
              if (len_q == 16'(i)) begin
                hdr_d[8*(13-i) +: 8] = crc_byte;
              end
            end
            if (len_q != 16'hFFFF) begin
              len_d = len_q + 16'd1;
            end
          end
        end else begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          ok_d        = (crc_val == CRC32_RESIDUE) && !nib_odd_q &&
                        (len_q >= MIN_LEN16) && (len_q <= MAX_LEN16);
          frame_len_d = len_q;
          da_d        = hdr_q[111:64];
          sa_d        = hdr_q[63:16];
          etype_d     = hdr_q[15:0];
        end
      end

      ST_DROP: begin
        if (!bus.io_mii_en) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All FSM and output registers; reset discards any frame in progress
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      lo_nib_q     <= '0;
      nib_odd_q    <= 1'b0;
      len_q        <= '0;
      hdr_q        <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
      frame_len_q  <= '0;
      da_q         <= '0;
      sa_q         <= '0;
      etype_q      <= '0;
    end else begin
      state_q      <= state_d;
      lo_nib_q     <= lo_nib_d;
      nib_odd_q    <= nib_odd_d;
      len_q        <= len_d;
      hdr_q        <= hdr_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      done_q       <= done_d;
      ok_q         <= ok_d;
      frame_len_q  <= frame_len_d;
      da_q         <= da_d;
      sa_q         <= sa_d;
      etype_q      <= etype_d;
    end
  end

  assign bus.io_byte_valid = byte_valid_q;
  assign bus.io_byte_data  = byte_data_q;
  assign bus.io_frame_done = done_q;
  assign bus.io_frame_ok   = ok_q;
  assign bus.io_frame_len  = frame_len_q;
  assign bus.io_da         = da_q;
  assign bus.io_sa         = sa_q;
  assign bus.io_etype      = etype_q;

`ifdef MII_FRAME_STATS_EN
  logic [31:0] good_cnt_d, good_cnt_q;
  logic [31:0] bad_cnt_d, bad_cnt_q;

  // Counters follow the visible done pulse so a clear on that cycle still keeps the new frame
  always_comb begin
    good_cnt_d = bus.io_stats_clr ? 32'd0 : good_cnt_q;
    bad_cnt_d  = bus.io_stats_clr ? 32'd0 : bad_cnt_q;
    if (done_q) begin
      if (ok_q) begin
        good_cnt_d = good_cnt_d + 32'd1;
      end else begin
        bad_cnt_d = bad_cnt_d + 32'd1;
      end
    end
  end

  // Frame counter registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign bus.io_good_cnt = good_cnt_q;
  assign bus.io_bad_cnt  = bad_cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = bus.io_stats_clr;
  assign bus.io_good_cnt  = '0;
  assign bus.io_bad_cnt   = '0;
`endif

endmodule

// File: tb/tb_mii_frame_monitor.sv
// Directed self-checking bench for mii_frame_monitor.
// Frames are built with an independent reflected CRC-32 model; expected counter
// values follow MII_FRAME_STATS_EN (zero when the macro is undefined).
module tb_mii_frame_monitor;

`ifdef MII_FRAME_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic clock;
  logic reset;

  mii_frame_monitor_if bus ();

  mii_frame_monitor dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int errors;
  int valid_cnt;
  int done_cnt;
  int v0;
  int d0;
  int exp_good;
  int exp_bad;
  logic [7:0]   frame_q[$];
  logic [7:0]   rx_q[$];
  logic [111:0] hdr_const;

  // Observe registered outputs on the falling edge, away from the sampling edge
  always @(negedge clock) begin
    if (bus.io_byte_valid === 1'b1) begin
      valid_cnt++;
      rx_q.push_back(bus.io_byte_data);
    end
    if (bus.io_frame_done === 1'b1) begin
      done_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] refFcs(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frame_q[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  task automatic buildFrame(input int total);
    logic [31:0] fcs;
    frame_q.delete();
    for (int i = 0; i < total - 4; i++) begin
      if (i < 14) frame_q.push_back(hdr_const[111-8*i -: 8]);
      else        frame_q.push_back(8'(i * 7 + 3));
    end
    fcs = refFcs(total - 4);
    frame_q.push_back(fcs[7:0]);
    frame_q.push_back(fcs[15:8]);
    frame_q.push_back(fcs[23:16]);
    frame_q.push_back(fcs[31:24]);
  endtask

  function automatic logic [111:0] expHdr();
    logic [111:0] h;
    h = '0;
    for (int i = 0; i < 14; i++) begin
      if (i < frame_q.size()) h[111-8*i -: 8] = frame_q[i];
    end
    return h;
  endfunction

  task automatic sendNibble(input logic [3:0] d);
    @(negedge clock);
    bus.io_mii_en  = 1'b1;
    bus.io_mii_dat = d;
  endtask

  task automatic sendByte(input logic [7:0] b);
    sendNibble(b[3:0]);
    sendNibble(b[7:4]);
  endtask

  task automatic sendPreamble(input int bad_pos);
    for (int i = 0; i < 15; i++) sendNibble((i == bad_pos) ? 4'h3 : 4'h5);
    sendNibble(4'hD);
  endtask

  task automatic dropEnable();
    @(negedge clock);
    bus.io_mii_en  = 1'b0;
    bus.io_mii_dat = 4'h0;
  endtask

  task automatic settle();
    repeat (5) @(negedge clock);
  endtask

  task automatic snap();
    v0 = valid_cnt;
    d0 = done_cnt;
  endtask

  // Full frame from frame_q: preamble, bytes, optional dribble nibble, one en-low sample
  task automatic applyStimulus(input int bad_pos, input bit dribble);
    sendPreamble(bad_pos);
    foreach (frame_q[i]) sendByte(frame_q[i]);
    if (dribble) sendNibble(4'hA);
    dropEnable();
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, "_good"}, 64'(bus.io_good_cnt), STATS_ON ? 64'(exp_good) : 64'd0);
    checkOutput({tag, "_bad"},  64'(bus.io_bad_cnt),  STATS_ON ? 64'(exp_bad)  : 64'd0);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_valid"}, 64'(bus.io_byte_valid), 64'd0);
    checkOutput({tag, "_data"},  64'(bus.io_byte_data),  64'd0);
    checkOutput({tag, "_done"},  64'(bus.io_frame_done), 64'd0);
    checkOutput({tag, "_ok"},    64'(bus.io_frame_ok),   64'd0);
    checkOutput({tag, "_len"},   64'(bus.io_frame_len),  64'd0);
    checkOutput({tag, "_da"},    64'(bus.io_da),         64'd0);
    checkOutput({tag, "_sa"},    64'(bus.io_sa),         64'd0);
    checkOutput({tag, "_etype"}, 64'(bus.io_etype),      64'd0);
    checkOutput({tag, "_good"},  64'(bus.io_good_cnt),   64'd0);
    checkOutput({tag, "_bad"},   64'(bus.io_bad_cnt),    64'd0);
  endtask

  initial begin
    int mism;
    logic [111:0] eh;
    checks    = 0;
    errors    = 0;
    valid_cnt = 0;
    done_cnt  = 0;
    exp_good  = 0;
    exp_bad   = 0;
    hdr_const = {48'h0A0B_0C0D_0E0F, 48'h1122_3344_5566, 16'h0800};
    reset            = 1'b0;
    bus.io_mii_en    = 1'b0;
    bus.io_mii_dat   = 4'h0;
    bus.io_stats_clr = 1'b0;

    repeat (3) @(negedge clock);
    checkZero("rst");
    reset = 1'b1;
    settle();

    // 1: good 64-byte frame
    $display("[TB] test 1: good frame");
    buildFrame(64);
    rx_q.delete();
    snap();
    applyStimulus(-1, 1'b0);
    settle();
    exp_good++;
    checkOutput("t1_done",  64'(done_cnt - d0), 64'd1);
    checkOutput("t1_ok",    64'(bus.io_frame_ok), 64'd1);
    checkOutput("t1_len",   64'(bus.io_frame_len), 64'd64);
    checkOutput("t1_da",    64'(bus.io_da), 64'h0A0B_0C0D_0E0F);
    checkOutput("t1_sa",    64'(bus.io_sa), 64'h1122_3344_5566);
    checkOutput("t1_etype", 64'(bus.io_etype), 64'h0800);
    checkOutput("t1_nbytes", 64'(rx_q.size()), 64'd64);
    mism = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < rx_q.size() && rx_q[i] !== frame_q[i]) mism++;
    end
    checkOutput("t1_bytes", 64'(mism), 64'd0);
    checkCounts("t1");

    // 2: one payload nibble flipped after FCS computed
    $display("[TB] test 2: corrupted payload");
    buildFrame(64);
    frame_q[20] = frame_q[20] ^ 8'h0F;
    applyStimulus(-1, 1'b0);
    settle();
    exp_bad++;
    checkOutput("t2_ok",  64'(bus.io_frame_ok), 64'd0);
    checkOutput("t2_len", 64'(bus.io_frame_len), 64'd64);
    checkCounts("t2");

    // 3: dribble nibble on an otherwise valid frame
    $display("[TB] test 3: dribble nibble");
    buildFrame(64);
    snap();
    applyStimulus(-1, 1'b1);
    settle();
    exp_bad++;
    checkOutput("t3_ok",    64'(bus.io_frame_ok), 64'd0);
    checkOutput("t3_len",   64'(bus.io_frame_len), 64'd64);
    checkOutput("t3_valid", 64'(valid_cnt - v0), 64'd64);

    // 4: runt, giant and a sub-header frame
    $display("[TB] test 4: length limits");
    buildFrame(60);
    applyStimulus(-1, 1'b0);
    settle();
    exp_bad++;
    checkOutput("t4_runt_ok",  64'(bus.io_frame_ok), 64'd0);
    checkOutput("t4_runt_len", 64'(bus.io_frame_len), 64'd60);
    buildFrame(1523);
    applyStimulus(-1, 1'b0);
    settle();
    exp_bad++;
    checkOutput("t4_giant_ok",  64'(bus.io_frame_ok), 64'd0);
    checkOutput("t4_giant_len", 64'(bus.io_frame_len), 64'd1523);
    buildFrame(10);
    applyStimulus(-1, 1'b0);
    settle();
    exp_bad++;
    eh = expHdr();
    checkOutput("t4_short_len",   64'(bus.io_frame_len), 64'd10);
    checkOutput("t4_short_da",    64'(bus.io_da), 64'(eh[111:64]));
    checkOutput("t4_short_sa",    64'(bus.io_sa), 64'(eh[63:16]));
    checkOutput("t4_short_etype", 64'(bus.io_etype), 64'd0);
    checkCounts("t4");

    // 5: bad preamble is dropped; good frame follows after a single idle sample
    $display("[TB] test 5: bad preamble");
    buildFrame(64);
    snap();
    applyStimulus(7, 1'b0);
    checkOutput("t5_drop_valid", 64'(valid_cnt - v0), 64'd0);
    checkOutput("t5_drop_done",  64'(done_cnt - d0), 64'd0);
    checkCounts("t5_drop");
    applyStimulus(-1, 1'b0);
    settle();
    exp_good++;
    checkOutput("t5_ok",   64'(bus.io_frame_ok), 64'd1);
    checkOutput("t5_done", 64'(done_cnt - d0), 64'd1);
    checkCounts("t5");

    // 6: reset mid-DATA, recovery, then clear coincident with done
    $display("[TB] test 6: reset mid-frame");
    buildFrame(64);
    snap();
    sendPreamble(-1);
    for (int i = 0; i < 20; i++) sendByte(frame_q[i]);
    @(negedge clock);
    reset         = 1'b0;
    bus.io_mii_en = 1'b0;
    @(negedge clock);
    checkZero("t6_rst");
    reset = 1'b1;
    exp_good = 0;
    exp_bad  = 0;
    settle();
    checkOutput("t6_no_done", 64'(done_cnt - d0), 64'd0);
    applyStimulus(-1, 1'b0);
    settle();
    exp_good++;
    checkOutput("t6_ok", 64'(bus.io_frame_ok), 64'd1);
    checkCounts("t6");
    applyStimulus(-1, 1'b0);
    @(negedge clock);
    bus.io_stats_clr = 1'b1;
    checkOutput("t6_clr_on_done", 64'(bus.io_frame_done), 64'd1);
    @(negedge clock);
    bus.io_stats_clr = 1'b0;
    settle();
    exp_good = 1;
    exp_bad  = 0;
    checkCounts("t6_clr");

    // 7: back-to-back good frames with one en-low sample between them
    $display("[TB] test 7: back-to-back");
    buildFrame(64);
    snap();
    applyStimulus(-1, 1'b0);
    applyStimulus(-1, 1'b0);
    settle();
    exp_good += 2;
    checkOutput("t7_done",  64'(done_cnt - d0), 64'd2);
    checkOutput("t7_valid", 64'(valid_cnt - v0), 64'd128);
    checkOutput("t7_ok",    64'(bus.io_frame_ok), 64'd1);
    checkCounts("t7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
